// File: rtl/weight_stream_reader.sv
// weight_stream_reader: streams a weight BRAM from address 0 through a 2-entry FIFO with ready/valid output
// Define WEIGHT_STREAM_CHECKSUM_EN to add a running modulo-2^DW CHECKSUM of transferred words.
module weight_stream_reader #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic [AW-1:0] ADDR,
    output logic          EN,
    output logic          WE,
    input  logic [DW-1:0] MEM_DO,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST,
    output logic          BUSY,
    output logic          DONE,
    output logic [DW-1:0] CHECKSUM
);
    localparam logic [AW:0]   CNT_MAX   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          en_q, en_d;
    logic [1:0]    occ_q, occ_d;
    logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
    logic          l0_q, l0_d, l1_q, l1_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          pop, wr1, can_issue;

    always_comb begin
        pop       = (occ_q != 2'd0) && W_READY;
        // occupancy at the end of this cycle; a read issued next cycle must still fit even if nothing drains
        occ_d     = occ_q + {1'b0, en_q} - {1'b0, pop};
        wr1       = occ_q != {1'b0, pop};
        can_issue = (cnt_q < CNT_MAX) && (occ_d < 2'd2);
        d0_d      = pop ? d1_q : d0_q;
        l0_d      = pop ? l1_q : l0_q;
        d1_d      = d1_q;
        l1_d      = l1_q;
        if (en_q && !wr1) begin
            d0_d = MEM_DO;
            l0_d = addr_q == LAST_ADDR;
        end
        if (en_q && wr1) begin
            d1_d = MEM_DO;
            l1_d = addr_q == LAST_ADDR;
        end
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                state_d = FETCH;
                en_d    = 1'b1;
                addr_d  = '0;
                cnt_d   = (AW+1)'(1);
            end
            FETCH: begin
                if (can_issue) begin
                    en_d   = 1'b1;
                    addr_d = cnt_q[AW-1:0];
                    cnt_d  = cnt_q + (AW+1)'(1);
                end
                state_d = (cnt_d == CNT_MAX) ? DRAIN : FETCH;
            end
            DRAIN: state_d = (pop && l0_q) ? FIN : DRAIN;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == FETCH) || (state_d == DRAIN);
        done_d = state_d == FIN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            en_q    <= 1'b0;
            occ_q   <= '0;
            d0_q    <= '0;
            d1_q    <= '0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            occ_q   <= occ_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef WEIGHT_STREAM_CHECKSUM_EN
    logic [DW-1:0] sum_q, sum_d;

    always_comb sum_d = (state_q == IDLE && START) ? '0 : pop ? sum_q + d0_q : sum_q;

    always_ff @(posedge CLK) begin
        if (RST) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign CHECKSUM = sum_q;
`else
    assign CHECKSUM = '0;
`endif

    assign ADDR    = addr_q;
    assign EN      = en_q;
    assign WE      = 1'b0;
    assign W_DATA  = d0_q;
    assign W_VALID = occ_q != 2'd0;
    assign W_LAST  = l0_q && (occ_q != 2'd0);
    assign BUSY    = busy_q;
    assign DONE    = done_q;
endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader: scoreboard bench; stimulus queues expected words, a negedge monitor checks them.
module tb_weight_stream_reader;
    logic        CLK = 1'b0;
    logic        RST, START, EN, WE, W_VALID, W_READY, W_LAST, BUSY, DONE;
    logic [4:0]  ADDR;
    logic [15:0] MEM_DO = '0, W_DATA, CHECKSUM;
    logic [15:0] mem [32];
    logic [3:0]  pat = 4'b1001;
    logic [16:0] exp_q [$];
    logic [16:0] e, held;
    bit          stall;
    int cyc = 0, vectors = 0, miscompares = 0;
    int exp_first, exp_done, stream_id = 0, seen_id = 0;
    int rst_req = 0, rst_ack = 0, to_req = 0, to_ack = 0;
    int occ_m = 0, exp_addr = 0, last_cyc = 0, xfers = 0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    logic [15:0] exp_sum;
`endif

    weight_stream_reader dut (
        .CLK(CLK), .RST(RST), .START(START), .ADDR(ADDR), .EN(EN), .WE(WE),
        .MEM_DO(MEM_DO), .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY),
        .W_LAST(W_LAST), .BUSY(BUSY), .DONE(DONE), .CHECKSUM(CHECKSUM)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (EN) MEM_DO <= mem[ADDR];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (rst_req != rst_ack) begin
            rst_ack = rst_req;
            check("reset_outputs", {ADDR, EN, WE, W_DATA, W_VALID, W_LAST, BUSY, DONE, CHECKSUM}, 0);
        end
        if (to_req != to_ack) begin
            to_ack = to_req;
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no DONE expected DONE within 400 cycles");
        end
        if (RST) begin
            exp_q.delete();
            occ_m = 0; exp_addr = 0; xfers = 0; stall = 0;
        end else begin
            if (EN) begin
                check("fifo_room_on_read", occ_m < 2, 1);
                check("read_addr", ADDR, exp_addr);
                exp_addr++;
            end
            if (stall) check("stall_hold", {W_VALID, W_LAST, W_DATA}, {1'b1, held});
            if (W_VALID && seen_id != stream_id) begin
                seen_id = stream_id;
                check("first_valid_cycle", cyc, exp_first);
            end
            if (W_VALID && W_READY) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h expected none", {W_LAST, W_DATA});
                end else begin
                    e = exp_q.pop_front();
                    check("word", {W_LAST, W_DATA}, e);
                end
                xfers++;
                last_cyc = cyc;
            end
            stall = W_VALID && !W_READY;
            held  = {W_LAST, W_DATA};
            occ_m = occ_m + int'(EN) - int'(W_VALID && W_READY);
            if (DONE) begin
                check("done_cycle", cyc, exp_done < 0 ? last_cyc + 1 : exp_done);
                check("busy_at_done", BUSY, 0);
                check("xfer_count", xfers, 28);
`ifdef WEIGHT_STREAM_CHECKSUM_EN
                check("checksum", CHECKSUM, exp_sum);
`else
                check("checksum", CHECKSUM, 0);
`endif
                xfers = 0;
                exp_addr = 0;
            end
        end
    end

    task automatic load(input bit ones);
        for (int i = 0; i < 32; i++) mem[i] = ones ? 16'hFFFF : 16'(i + 1);
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        exp_sum = ones ? 16'hFFE4 : 16'd406;
`endif
    endtask

    // mode 0: ready held 1; 1: ready 1,0,0,1 pattern; 2: STARTs while busy and in FIN; 3: reset after 10 transfers
    task automatic go(input int mode);
        int s, n;
        for (int i = 0; i < 28; i++) exp_q.push_back({i == 27, mem[i]});
        s = cyc;
        exp_first = s + 2;
        exp_done = mode == 1 ? -1 : s + 30;
        stream_id++;
        START = 1'b1;
        W_READY = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        for (n = 1; n < 400 && !DONE && !(mode == 3 && xfers >= 10); n++) begin
            W_READY = mode == 1 ? pat[n % 4] : 1'b1;
            START = mode == 2 && (n == 3 || n == 10);
            @(posedge CLK); #1;
        end
        START = 1'b0;
        W_READY = 1'b1;
        if (n >= 400) to_req++;
        if (mode == 3) begin
            RST = 1'b1;
            @(posedge CLK); #1;
            RST = 1'b0;
            rst_req++;
        end else if (mode == 2) begin
            START = 1'b1;
            @(posedge CLK); #1;
            START = 1'b0;
        end
        repeat (4) @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        START = 1'b0;
        W_READY = 1'b1;
        load(1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        rst_req++;
        @(posedge CLK); #1;
        go(0);
        go(1);
        go(2);
        go(3);
        go(0);
        load(1'b1);
        go(0);
        @(negedge CLK); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
